// File: rtl/control_unit_downsample_if.sv
// control_unit_downsample_if
//   Groups the frame-pass control and memory signals of the 2x2 average-pool
//   downsampler. clk and rst are not in this bundle; they stay plain module ports.
//
//   start            begin one frame pass (only looked at while idle)
//   size_downsample  input side N = 8 << code, codes above 4 behave as 4
//   data_in          signed input pixel, one cycle after its read strobe
//   en_read_in       input-memory read strobe
//   addr_input       input-memory read address, row-major
//   en_write_out     output-memory write strobe
//   addr_output      output-memory write address, row-major
//   data_out         signed pooled pixel, valid with en_write_out
//   busy             high whenever a pass is in progress
//   done             one-cycle pulse at the end of a pass
//
//   master: drives start/size/data_in (controller or memory side)
//   slave : the downsampler itself
interface control_unit_downsample_if;
  logic               start;
  logic [2:0]         size_downsample;
  logic signed [15:0] data_in;
  logic               en_read_in;
  logic [13:0]        addr_input;
  logic               en_write_out;
  logic [13:0]        addr_output;
  logic signed [15:0] data_out;
  logic               busy;
  logic               done;

  modport master (
    output start, size_downsample, data_in,
    input  en_read_in, addr_input, en_write_out, addr_output, data_out, busy, done
  );

  modport slave (
    input  start, size_downsample, data_in,
    output en_read_in, addr_input, en_write_out, addr_output, data_out, busy, done
  );
endinterface

// File: rtl/control_unit_downsample.sv
// control_unit_downsample
//   2x2 average-pool decimator: reads an N x N signed image (N = 8..128) from
//   an input memory and writes the N/2 x N/2 image of window averages to an
//   output memory. Each output pixel takes six cycles: four reads, one cycle
//   to absorb the last read's latency, one write.
//
//   Ports:
//     clk  rising-edge system clock
//     rst  asynchronous, active-low reset
//     bus  control_unit_downsample_if.slave (start/size/data_in in, memory
//          strobes, addresses, data_out, busy, done out)
//
//   Build option:
//     DOWNSAMPLE_ROUND_EN  defined   -> data_out = (sum + 2) >>> 2 (round half up)
//                          undefined -> data_out = sum >>> 2       (floor)
module control_unit_downsample (
  input logic                     clk,
  input logic                     rst,
  control_unit_downsample_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    ACC  = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [2:0]         size_code;   // latched and clamped to 0..4
  logic [5:0]         ox;
  logic [5:0]         oy;
  logic signed [17:0] acc;
  logic [6:0]         half;        // output side N/2
  logic               last_col;
  logic               last_row;
  logic               dy;
  logic               dx;
  logic [13:0]        row;
  logic [13:0]        col;
  logic signed [18:0] acc_adj;

  assign half     = 7'd4 << size_code;
  assign last_col = ({1'b0, ox} == half - 7'd1);
  assign last_row = ({1'b0, oy} == half - 7'd1);

  // One extra bit so the rounding bias can never overflow the window sum.
`ifdef DOWNSAMPLE_ROUND_EN
  assign acc_adj = 19'(acc) + 19'sd2;
`else
  assign acc_adj = 19'(acc);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a fixed six-state loop per output pixel.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RD0;
      RD0:     next_state = RD1;
      RD1:     next_state = RD2;
      RD2:     next_state = RD3;
      RD3:     next_state = ACC;
      ACC:     next_state = WR;
      WR:      next_state = (last_col && last_row) ? DONE : RD0;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: size latch, output-pixel coordinates and window accumulator.
  // data_in lags its read strobe by one cycle, so the four samples land in
  // RD1, RD2, RD3 and ACC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_code <= 3'd0;
      ox        <= 6'd0;
      oy        <= 6'd0;
      acc       <= 18'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            size_code <= (bus.size_downsample > 3'd4) ? 3'd4 : bus.size_downsample;
            ox        <= 6'd0;
            oy        <= 6'd0;
          end
        end
        RD0: acc <= 18'sd0;
        RD1, RD2, RD3, ACC: acc <= acc + 18'(bus.data_in);
        WR: begin
          if (last_col) begin
            ox <= 6'd0;
            oy <= last_row ? 6'd0 : oy + 6'd1;
          end else begin
            ox <= ox + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; addresses and data are zero whenever their
  // strobe is low. Multiplying by N or N/2 is a shift by the size code.
  always_comb begin
    bus.busy         = (state != IDLE);
    bus.done         = (state == DONE);
    bus.en_read_in   = 1'b0;
    bus.en_write_out = 1'b0;
    bus.addr_input   = 14'd0;
    bus.addr_output  = 14'd0;
    bus.data_out     = 16'sd0;
    dy               = 1'b0;
    dx               = 1'b0;
    case (state)
      RD0: bus.en_read_in = 1'b1;
      RD1: begin
        bus.en_read_in = 1'b1;
        dx             = 1'b1;
      end
      RD2: begin
        bus.en_read_in = 1'b1;
        dy             = 1'b1;
      end
      RD3: begin
        bus.en_read_in = 1'b1;
        dy             = 1'b1;
        dx             = 1'b1;
      end
      WR: bus.en_write_out = 1'b1;
      default: ;
    endcase
    row = 14'({oy, 1'b0}) + 14'(dy);
    col = 14'({ox, 1'b0}) + 14'(dx);
    if (bus.en_read_in) begin
      bus.addr_input = (row << (size_code + 3'd3)) + col;
    end
    if (bus.en_write_out) begin
      bus.addr_output = (14'(oy) << (size_code + 3'd2)) + 14'(ox);
      bus.data_out    = 16'(acc_adj >>> 2);
    end
  end

endmodule

// File: tb/tb_control_unit_downsample.sv
// tb_control_unit_downsample
//   Self-checking bench for control_unit_downsample. A behavioural memory
//   feeds data_in one cycle after each read strobe; a monitor on the falling
//   edge compares every read address, write address and pooled value against
//   window averages computed directly from the memory image.
//   Honours DOWNSAMPLE_ROUND_EN the same way as the design.
module tb_control_unit_downsample;

`ifdef DOWNSAMPLE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_unit_downsample_if bus ();

  control_unit_downsample dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [15:0] mem [0:16383];

  int  check_cnt = 0;
  int  pass_cnt  = 0;
  bit  mon_en = 1'b0;
  bit  expect_active = 1'b0;
  int  m_half = 4;
  int  m_n = 8;
  int  rd_idx = 0;
  int  wr_idx = 0;
  int  last_rd_addr = -1;
  int  last_wr_addr = -1;
  int  wr_data [$];

  // Input memory with one cycle of read latency; garbage when not read.
  always @(posedge clk) begin
    if (bus.en_read_in === 1'b1) bus.data_in <= mem[bus.addr_input];
    else                         bus.data_in <= 16'($urandom);
  end

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int floor_div4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  // Reference: i-th read of a pass, pixels row-major, window order
  // (0,0),(0,1),(1,0),(1,1).
  function automatic int exp_read_addr(input int idx);
    int p = idx / 4;
    int k = idx % 4;
    int oy = p / m_half;
    int ox = p % m_half;
    return (2 * oy + k / 2) * m_n + 2 * ox + k % 2;
  endfunction

  function automatic int exp_pixel(input int p);
    int oy = p / m_half;
    int ox = p % m_half;
    int s = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        s += int'(mem[(2 * oy + dy) * m_n + 2 * ox + dx]);
    if (ROUND) s += 2;
    return floor_div4(s);
  endfunction

  // Falling-edge monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      check_output("no_overlap", 32'(bus.en_read_in & bus.en_write_out), 0);
      if (bus.en_read_in !== 1'b1) check_output("rd_addr_idle", 32'(bus.addr_input), 0);
      if (bus.en_write_out !== 1'b1) check_output("wr_addr_idle", 32'(bus.addr_output), 0);
      if (!expect_active) begin
        check_output("stray_read", 32'(bus.en_read_in), 0);
        check_output("stray_write", 32'(bus.en_write_out), 0);
      end else begin
        if (bus.en_read_in === 1'b1) begin
          check_output("rd_addr", 32'(bus.addr_input), exp_read_addr(rd_idx));
          last_rd_addr = int'(bus.addr_input);
          rd_idx++;
        end
        if (bus.en_write_out === 1'b1) begin
          check_output("wr_addr", 32'(bus.addr_output), wr_idx);
          check_output("wr_data", 32'(bus.data_out), exp_pixel(wr_idx));
          last_wr_addr = int'(bus.addr_output);
          wr_data.push_back(int'(bus.data_out));
          wr_idx++;
        end
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
  endtask

  // Pulse start with the given size code and return 1 time unit after the
  // start-sampling edge; size_downsample is then scrambled to prove it is latched.
  task automatic start_pass(input int code, input bit hold_start);
    int hc = (code > 4) ? 4 : code;
    m_half = 4 << hc;
    m_n = 8 << hc;
    rd_idx = 0;
    wr_idx = 0;
    wr_data.delete();
    expect_active = 1'b1;
    @(negedge clk);
    bus.size_downsample = 3'(code);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.size_downsample = 3'($urandom);
    if (!hold_start) bus.start = 1'b0;
  endtask

  task automatic run_pass(input int code, input bit hold_start, input string tag);
    int cyc = 1;
    int total;
    start_pass(code, hold_start);
    total = m_half * m_half;
    while (bus.done !== 1'b1 && cyc < 6 * total + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output({tag, "_done_cycle"}, cyc, 6 * total + 1);
    check_output({tag, "_busy_in_done"}, 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_output({tag, "_done_pulse"}, 32'(bus.done), 0);
    check_output({tag, "_busy_after"}, 32'(bus.busy), 0);
    check_output({tag, "_writes"}, wr_idx, total);
    check_output({tag, "_reads"}, rd_idx, 4 * total);
    expect_active = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output({tag, "_stays_idle"}, 32'(bus.busy), 0);
  endtask

  task automatic apply_stimulus_reset_check(input string tag);
    check_output({tag, "_busy"}, 32'(bus.busy), 0);
    check_output({tag, "_done"}, 32'(bus.done), 0);
    check_output({tag, "_en_read"}, 32'(bus.en_read_in), 0);
    check_output({tag, "_en_write"}, 32'(bus.en_write_out), 0);
    check_output({tag, "_addr_in"}, 32'(bus.addr_input), 0);
    check_output({tag, "_addr_out"}, 32'(bus.addr_output), 0);
    check_output({tag, "_data_out"}, 32'(bus.data_out), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.size_downsample = 3'd0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset with random inputs: everything stays zero.
    $display("[TB] reset with random inputs");
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'($urandom);
      bus.size_downsample = 3'($urandom);
      #1;
      apply_stimulus_reset_check("reset");
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus_reset_check("post_release");

    // Size 0 with data equal to the read address.
    $display("[TB] ramp pass, size 0");
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i);
    run_pass(0, 1'b0, "ramp");
    if (wr_data.size() == 16) begin
      check_output("ramp_first_data", wr_data[0], ROUND ? 5 : 4);
      check_output("ramp_last_data", wr_data[15], ROUND ? 59 : 58);
    end
    check_output("ramp_last_addr", last_wr_addr, 15);

    // Negative and saturating windows.
    $display("[TB] signed extremes, size 0");
    fill_random();
    mem[0] = -16'sd4;  mem[1] = -16'sd3;  mem[8] = -16'sd3;  mem[9] = -16'sd3;
    mem[2] = 16'sd32767; mem[3] = 16'sd32767; mem[10] = 16'sd32767; mem[11] = 16'sd32767;
    run_pass(0, 1'b0, "neg");
    if (wr_data.size() >= 2) begin
      check_output("neg_window", wr_data[0], ROUND ? -3 : -4);
      check_output("max_window", wr_data[1], 32767);
    end

    // start held through the whole pass and the DONE cycle: one pass only.
    $display("[TB] start held high, size 1");
    fill_random();
    run_pass(1, 1'b1, "hold");

    // Reset in cycle 40 of a size-1 pass.
    $display("[TB] reset mid-pass, size 1");
    fill_random();
    start_pass(1, 1'b0);
    repeat (39) @(posedge clk);
    #3;
    expect_active = 1'b0;
    rst = 1'b0;
    #1;
    apply_stimulus_reset_check("midpass_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("midpass_no_resume", 32'(bus.busy), 0);
    run_pass(1, 1'b0, "after_rst");

    // Oversized code behaves as code 4.
    $display("[TB] size code 7");
    fill_random();
    run_pass(7, 1'b0, "size7");
    check_output("size7_last_wr_addr", last_wr_addr, 4095);
    check_output("size7_last_rd_addr", last_rd_addr, 16383);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit_downsample.md
CONTROL_UNIT_DOWNSAMPLE -- requirements
Module: control_unit_downsample

Interface
REQ-001 SHALL have: clk  input  1  single system clock, rising-edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  input  1  begin one frame pass, sampled only in IDLE.
REQ-004 SHALL have: size_downsample  input  3  input side N = 8<<code (0..4 -> 8..128); codes 5..7 treated as 4.
REQ-005 SHALL have: data_in  input  16  signed input pixel, valid one cycle after its en_read_in/addr_input.
REQ-006 SHALL have: en_read_in  output  1  input-memory read strobe.
REQ-007 SHALL have: addr_input  output  14  input-memory read address, row-major.
REQ-008 SHALL have: en_write_out  output  1  output-memory write strobe.
REQ-009 SHALL have: addr_output  output  14  output-memory write address, row-major.
REQ-010 SHALL have: data_out  output  16  signed pooled pixel, valid with en_write_out.
REQ-011 SHALL have: busy  output  1  high in every non-IDLE state.
REQ-012 SHALL have: done  output  1  one-cycle pulse at end of pass.

Function
REQ-013 SHALL perform 2x2 average-pool decimation: N x N input -> N/2 x N/2 output, the inverse of the 2x upsampler.
REQ-014 SHALL latch size_downsample when start is accepted; later changes ignored until next pass.
REQ-015 SHALL implement states IDLE, RD0, RD1, RD2, RD3, ACC, WR, DONE.
REQ-016 Transitions SHALL be: IDLE->RD0 on start; RDk->RDk+1; RD3->ACC; ACC->WR; WR->RD0 if output pixels remain, else WR->DONE; DONE->IDLE unconditionally.
REQ-017 For output pixel (oy,ox), RD0..RD3 SHALL assert en_read_in with addr_input = (2oy+dy)*N + (2ox+dx), (dy,dx) = (0,0),(0,1),(1,0),(1,1) in order.
REQ-018 Accumulator (18-bit signed) SHALL clear in RD0, add sign-extended data_in in RD1, RD2, RD3 and ACC (one-cycle read latency).
REQ-019 WR SHALL assert en_write_out for exactly one cycle with data_out = sum>>>2 (arithmetic shift, floor) and addr_output = oy*(N/2)+ox.
REQ-020 Output pixels SHALL be visited row-major; addr_output increments by 1 per WR starting at 0.
REQ-021 Each output pixel SHALL take exactly 6 cycles; a pass SHALL take 6*(N/2)^2 cycles from RD0 to final WR inclusive.
REQ-022 done SHALL be high only in DONE (one cycle, after final WR); busy low in DONE is forbidden.
REQ-023 start asserted outside IDLE (including DONE) SHALL be ignored.
REQ-024 en_read_in and en_write_out SHALL never be high in the same cycle; addresses SHALL hold 0 when their strobe is low.

Reset
REQ-025 rst low SHALL immediately force IDLE and all outputs, counters, accumulator to 0, including mid-pass.
REQ-026 After rst release the block SHALL wait for a new start; no partial pass resumes.

Configuration
REQ-027 Macro DOWNSAMPLE_ROUND_EN defined: data_out SHALL be (sum+2)>>>2 (round half up); undefined: data_out SHALL be sum>>>2 (floor); no other behaviour differs.

Verification
REQ-028 Reset: rst=0 with random inputs -> all outputs 0, busy=0; hold through release.
REQ-029 size=0, memory data_in = read address: first WR addr_output=0, data_out=4 (sum 18; 5 with ROUND_EN); last WR addr_output=15, data_out=58 (sum 234; 59 with ROUND_EN); done high exactly in cycle 97 after start-sampling edge, 16 writes total.
REQ-030 Negative data: window -4,-3,-3,-3 -> data_out=-4 (floor), -3 with ROUND_EN; window 32767 x4 -> 32767 in both builds.
REQ-031 start held high for whole pass and pulsed during DONE -> exactly one pass executed, returns to IDLE.
REQ-032 rst pulsed low at cycle 40 of a size=1 pass -> outputs 0 asynchronously, no further writes until next start; following pass completes normally with 64 writes.
REQ-033 size=7 -> behaves as size 4: 4096 writes, last addr_output=4095, last addr_input=16383.
